counter_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the 5-bit loadable counter and drives its `load`, `en` and `data_in` inputs. It accepts a stream of commands over a valid/ready handshake (load a value, count for N cycles, hold for N cycles) and converts each command into cycle-exact control pulses. Tests and higher-level control issue intent-level commands rather than toggling counter controls cycle by cycle.

---
 rtl/counter_cmd_seq_pkg.sv | 24 ++
 rtl/counter_cmd_seq_timer.sv | 32 +++
 rtl/counter_cmd_seq.sv | 128 ++++++++++++
 tb/tb_counter_cmd_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/counter_cmd_seq_pkg.sv
// Shared types for the counter command sequencer: command opcodes and FSM states.
// Also holds a small decode helper used by the top level.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_LOAD = 2'd1,
        OP_RUN  = 2'd2,
        OP_HOLD = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HOLD = 2'd3
    } seq_state_t;

    // RUN and HOLD are the only opcodes that consume a duration
    function automatic logic is_timed_op(input cmd_op_t op);
        return (op == OP_RUN) || (op == OP_HOLD);
    endfunction

endpackage

// File: rtl/counter_cmd_seq_timer.sv
// Duration down-counter for RUN/HOLD commands; o_last flags the final cycle.
module seq_len_timer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             syn_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_clear,
    output logic             o_last
);

    logic [LEN_W-1:0] r_remaining;

    // Load on start, otherwise count down to zero; clear discards the count
    always_ff @(posedge clk) begin
        if (!syn_rst_n) begin
            r_remaining <= {LEN_W{1'b0}};
        end else if (i_clear) begin
            r_remaining <= {LEN_W{1'b0}};
        end else if (i_start) begin
            r_remaining <= i_len;
        end else if (r_remaining != {LEN_W{1'b0}}) begin
            r_remaining <= r_remaining - {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            r_remaining <= r_remaining;
        end
    end

    assign o_last = (r_remaining == {{(LEN_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/counter_cmd_seq.sv
// Command sequencer: turns LOAD/RUN/HOLD/NOP commands into cycle-exact
// load/en/data_in pulses for a downstream loadable counter.
module counter_cmd_seq
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             syn_rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    input  logic             abort,
    output logic             load,
    output logic             en,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done
);

    seq_state_t       r_state;
    logic             r_load;
    logic             r_en;
    logic             r_done;
    logic [WIDTH-1:0] r_data_in;

    cmd_op_t w_op;
    logic    w_accept;
    logic    w_len_zero;
    logic    w_timer_start;
    logic    w_timer_clear;
    logic    w_last;

    assign w_op          = cmd_op_t'(cmd_op);
    assign cmd_ready     = (r_state == S_IDLE) && !abort;
    assign busy          = (r_state != S_IDLE);
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_len_zero    = (cmd_len == {LEN_W{1'b0}});
    assign w_timer_start = w_accept && is_timed_op(w_op) && !w_len_zero;
    assign w_timer_clear = abort && busy;

    seq_len_timer #(.LEN_W(LEN_W)) u_timer (
        .clk       (clk),
        .syn_rst_n (syn_rst_n),
        .i_start   (w_timer_start),
        .i_len     (cmd_len),
        .i_clear   (w_timer_clear),
        .o_last    (w_last)
    );

    // Sequencer FSM and registered counter controls
    always_ff @(posedge clk) begin
        if (!syn_rst_n) begin
            r_state   <= S_IDLE;
            r_load    <= 1'b0;
            r_en      <= 1'b0;
            r_done    <= 1'b0;
            r_data_in <= {WIDTH{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_LOAD: begin
                                r_state   <= S_LOAD;
                                r_load    <= 1'b1;
                                r_data_in <= cmd_data;
                            end
                            OP_RUN: begin
                                if (w_len_zero) begin
                                    r_done <= 1'b1;
                                end else begin
                                    r_state <= S_RUN;
                                    r_en    <= 1'b1;
                                end
                            end
                            OP_HOLD: begin
                                if (w_len_zero) begin
                                    r_done <= 1'b1;
                                end else begin
                                    r_state <= S_HOLD;
                                end
                            end
                            default: begin
                                r_done <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    // load is a single-cycle strobe; abort only suppresses done
                    r_state <= S_IDLE;
                    r_load  <= 1'b0;
                    r_done  <= !abort;
                end
                S_RUN, S_HOLD: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_en    <= 1'b0;
                    end else if (w_last) begin
                        r_state <= S_IDLE;
                        r_en    <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_load  <= 1'b0;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign load    = r_load;
    assign en      = r_en;
    assign done    = r_done;
    assign data_in = r_data_in;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq: directed scenarios then random traffic, checked
// against a busy-time/command-effect model and a counter fed by the DUT controls.
module tb_counter_cmd_seq;

    localparam int WIDTH = 5;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             syn_rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'd0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             abort = 1'b0;
    logic             cmd_ready, load, en, busy, done;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] cnt;

    int checks = 0;
    int errors = 0;

    // reference model: how many busy cycles remain and what the controls should be
    int m_known = 0;
    int m_busy_left = 0;
    int m_load = 0, m_en = 0, m_done = 0, m_data = 0, m_cnt = 0;
    bit m_acc = 1'b0;
    int done_seen = 0, en_seen = 0;

    counter_cmd_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .syn_rst_n(syn_rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_ready(cmd_ready), .abort(abort),
        .load(load), .en(en), .data_in(data_in), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // the downstream 5-bit loadable counter
    always @(posedge clk) begin
        if (!syn_rst_n) cnt <= '0;
        else if (load)  cnt <= data_in;
        else if (en)    cnt <= cnt + 5'd1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input bit rst, input bit v, input int op, input int data, input int len, input bit ab);
        syn_rst_n = rst; cmd_valid = v; cmd_op = 2'(op);
        cmd_data = WIDTH'(data); cmd_len = LEN_W'(len); abort = ab;
        #3;
        if (m_known != 0) begin
            check_val("cmd_ready", 32'(cmd_ready), 32'((m_busy_left == 0) && !ab));
            check_val("busy_pre", 32'(busy), 32'(m_busy_left != 0));
        end
        m_acc = rst && v && (m_busy_left == 0) && !ab;
        @(posedge clk);
        if (!rst) begin
            m_known = 1; m_busy_left = 0; m_load = 0; m_en = 0; m_done = 0; m_data = 0; m_cnt = 0;
        end else begin
            if (m_load != 0)    m_cnt = m_data;
            else if (m_en != 0) m_cnt = (m_cnt + 1) % 32;
            m_done = 0;
            if (m_busy_left > 0) begin
                if (ab) begin
                    m_busy_left = 0; m_load = 0; m_en = 0;
                end else begin
                    m_busy_left--;
                    if (m_busy_left == 0) begin m_load = 0; m_en = 0; m_done = 1; end
                end
            end else if (m_acc) begin
                if (op == 1) begin
                    m_busy_left = 1; m_load = 1; m_data = data % 32;
                end else if ((op == 2 || op == 3) && len > 0) begin
                    m_busy_left = len; m_en = (op == 2) ? 1 : 0;
                end else begin
                    m_done = 1;
                end
            end
        end
        #1;
        if (m_known != 0) begin
            check_val("load", 32'(load), 32'(m_load));
            check_val("en", 32'(en), 32'(m_en));
            check_val("done", 32'(done), 32'(m_done));
            check_val("data_in", 32'(data_in), 32'(m_data));
            check_val("busy", 32'(busy), 32'(m_busy_left != 0));
            check_val("counter", 32'(cnt), 32'(m_cnt));
            check_val("load_en_excl", 32'(load && en), 32'd0);
        end
        done_seen += int'(done);
        en_seen   += int'(en);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
    endtask

    // hold cmd_valid until the command is taken, bounded by a cycle budget
    task automatic issue(input int op, input int data, input int len);
        bit taken = 1'b0;
        for (int k = 0; k < 300; k++) begin
            cyc(1'b1, 1'b1, op, data, len, 1'b0);
            if (m_acc) begin taken = 1'b1; break; end
        end
        check_val("accept_timeout", 32'(taken), 32'd1);
    endtask

    initial begin
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1, 7, 0, 1'b1);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_data", 32'(data_in), 32'd0);

        // LOAD 21
        done_seen = 0;
        issue(1, 21, 0);
        check_val("load21_strobe", 32'(load), 32'd1);
        check_val("load21_data", 32'(data_in), 32'd21);
        idle(3);
        check_val("load21_cnt", 32'(cnt), 32'd21);
        check_val("load21_done_cnt", 32'(done_seen), 32'd1);

        // LOAD 28 then RUN 10 back-to-back: wrap to 6
        done_seen = 0; en_seen = 0;
        issue(1, 28, 0);
        issue(2, 0, 10);
        idle(12);
        check_val("wrap_cnt", 32'(cnt), 32'd6);
        check_val("wrap_en_cycles", 32'(en_seen), 32'd10);
        check_val("wrap_done_cnt", 32'(done_seen), 32'd2);

        // RUN 3 from 0 then HOLD 5
        issue(1, 0, 0);
        issue(2, 0, 3);
        issue(3, 0, 5);
        for (int k = 0; k < 5; k++) begin
            check_val("hold_cnt", 32'(cnt), 32'd3);
            check_val("hold_ready", 32'(cmd_ready), 32'd0);
            idle(1);
        end
        idle(2);

        // RUN 0 and NOP
        en_seen = 0;
        issue(2, 0, 0);
        check_val("run0_done", 32'(done), 32'd1);
        check_val("run0_busy", 32'(busy), 32'd0);
        issue(0, 0, 0);
        check_val("nop_done", 32'(done), 32'd1);
        idle(2);
        check_val("run0_nop_en", 32'(en_seen), 32'd0);

        // RUN 20 aborted at cycle 7
        issue(1, 0, 0);
        idle(2);
        done_seen = 0;
        issue(2, 0, 20);
        idle(6);
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b1);
        check_val("abort_en", 32'(en), 32'd0);
        idle(3);
        check_val("abort_cnt", 32'(cnt), 32'd7);
        check_val("abort_no_done", 32'(done_seen), 32'd0);
        cyc(1'b1, 1'b1, 1, 9, 0, 1'b1);
        check_val("abort_idle_block", 32'(busy), 32'd0);
        check_val("abort_idle_data", 32'(data_in), 32'd0);

        // reset mid-RUN 15
        issue(2, 0, 15);
        idle(4);
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
        check_val("rst_outs", 32'({load, en, done, busy, data_in}), 32'd0);
        issue(1, 3, 0);
        idle(2);
        check_val("post_rst_load", 32'(cnt), 32'd3);
        issue(2, 0, 2);
        idle(3);
        check_val("post_rst_run", 32'(cnt), 32'd5);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 12)), ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
